key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 146 ++++++++++++++
 tb/tb_key_debounce.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Pushbutton debouncer: two-flop synchronizer feeding a four-state FSM with press/release strobes.
// Defining KEY_REPEAT_EN adds auto-repeat press_pulse strobes while the key stays held.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       key_n,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [1:0] dbg_state
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_badParams
    $error("key_debounce: illegal parameter value");
  end

  state_t           r_state;
  state_t           w_nextState;
  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_pressedNext;
  logic             w_pressPulseNext;
  logic             w_releasePulseNext;
  logic             w_repeatFire;

  // r_sync2 holds the synchronized, inverted key (1 = pressed)
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= ~key_n;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_cntNext;
    end
  end

  // The counter is cleared on every wait-state entry, so it never needs to wrap
  always_comb begin
    w_nextState = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      IDLE: begin
        if (r_sync2) begin
          w_nextState = PRESS_WAIT;
          w_cntNext   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!r_sync2)              w_nextState = IDLE;
        else if (r_cnt == CNT_LAST) w_nextState = HELD;
        else                        w_cntNext   = r_cnt + 1'b1;
      end
      HELD: begin
        if (!r_sync2) begin
          w_nextState = RELEASE_WAIT;
          w_cntNext   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (r_sync2)                w_nextState = HELD;
        else if (r_cnt == CNT_LAST) w_nextState = IDLE;
        else                        w_cntNext   = r_cnt + 1'b1;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_pressedNext      = (w_nextState == HELD) || (w_nextState == RELEASE_WAIT);
    w_pressPulseNext   = ((r_state == PRESS_WAIT) && (w_nextState == HELD)) || w_repeatFire;
    w_releasePulseNext = (r_state == RELEASE_WAIT) && (w_nextState == IDLE);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      pressed       <= w_pressedNext;
      press_pulse   <= w_pressPulseNext;
      release_pulse <= w_releasePulseNext;
    end
  end

  assign dbg_state = r_state;

`ifdef KEY_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] r_rptCnt;
  logic             r_rptPhase;
  logic             w_rptStay;

  // Any cycle not spent staying in HELD restarts the initial delay phase
  assign w_rptStay    = (r_state == HELD) && (w_nextState == HELD);
  assign w_repeatFire = w_rptStay && (r_rptCnt == (r_rptPhase ? PERIOD_LAST : DELAY_LAST));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_rptCnt   <= '0;
      r_rptPhase <= 1'b0;
    end else if (!w_rptStay) begin
      r_rptCnt   <= '0;
      r_rptPhase <= 1'b0;
    end else if (w_repeatFire) begin
      r_rptCnt   <= '0;
      r_rptPhase <= 1'b1;
    end else begin
      r_rptCnt   <= r_rptCnt + 1'b1;
    end
  end
`else
  assign w_repeatFire = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: expected pulse cycles are queued when the key is driven
// and popped when the DUT strobes press_pulse/release_pulse.
module tb_key_debounce;

  logic       clk;
  logic       clr_n;
  logic       key_n;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic [1:0] dbg_state;

  int totalChecks = 0;
  int badChecks   = 0;
  int cyc         = 0;
  int expPress[$];
  int expRelease[$];
  int expCyc;
  int base;

  key_debounce #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .clr_n(clr_n),
    .key_n(key_n),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; drives the key and waits holdCycles falling edges
  task automatic applyStimulus(input logic val, input int holdCycles);
    key_n = val;
    repeat (holdCycles) @(negedge clk);
  endtask

  task automatic checkLevels(input string tag, input int expPressed, input int expState);
    checkOutput({tag, "_pressed"}, int'(pressed), expPressed);
    checkOutput({tag, "_state"}, int'(dbg_state), expState);
  endtask

  task automatic releaseKey(input string tag);
    expRelease.push_back(cyc + 7);
    applyStimulus(1'b1, 10);
    checkLevels(tag, 0, 0);
  endtask

  task automatic checkDrained(input string tag);
    checkOutput({tag, "_pressLeft"}, expPress.size(), 0);
    checkOutput({tag, "_releaseLeft"}, expRelease.size(), 0);
  endtask

  always @(negedge clk) begin
    if (press_pulse && release_pulse) checkOutput("pulseOverlap", 1, 0);
    if (press_pulse) begin
      if (expPress.size() == 0) checkOutput("pressUnexpected", cyc, -1);
      else begin
        expCyc = expPress.pop_front();
        checkOutput("pressCycle", cyc, expCyc);
      end
    end
    if (release_pulse) begin
      if (expRelease.size() == 0) checkOutput("releaseUnexpected", cyc, -1);
      else begin
        expCyc = expRelease.pop_front();
        checkOutput("releaseCycle", cyc, expCyc);
      end
    end
  end

  initial begin
    clr_n = 1'b0;
    key_n = 1'b1;
    repeat (3) @(negedge clk);
    checkLevels("reset", 0, 0);
    checkOutput("reset_pressPulse", int'(press_pulse), 0);
    checkOutput("reset_releasePulse", int'(release_pulse), 0);
    clr_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] clean press and release");
    expPress.push_back(cyc + 7);
    applyStimulus(1'b0, 10);
    checkLevels("clean", 1, 2);
    checkOutput("clean_pulseLow", int'(press_pulse), 0);
    releaseKey("cleanRel");
    checkDrained("clean");

    $display("[TB] bounce on press");
    applyStimulus(1'b0, 3);
    checkLevels("bounce", 0, 1);
    applyStimulus(1'b1, 2);
    expPress.push_back(cyc + 7);
    applyStimulus(1'b0, 10);
    checkLevels("bounceHeld", 1, 2);
    releaseKey("bounceRel");
    checkDrained("bounce");

    $display("[TB] release glitch");
    expPress.push_back(cyc + 7);
    applyStimulus(1'b0, 9);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 1);
    checkLevels("glitchWait", 1, 3);
    applyStimulus(1'b0, 5);
    checkLevels("glitchBack", 1, 2);
    releaseKey("glitchRel");
    checkDrained("glitch");

    $display("[TB] reset while held");
    expPress.push_back(cyc + 7);
    applyStimulus(1'b0, 9);
    clr_n = 1'b0;
    #1;
    checkLevels("midReset", 0, 0);
    checkOutput("midReset_pressPulse", int'(press_pulse), 0);
    checkOutput("midReset_releasePulse", int'(release_pulse), 0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    expPress.push_back(cyc + 7);
    repeat (10) @(negedge clk);
    checkLevels("afterReset", 1, 2);
    releaseKey("resetRel");
    checkDrained("reset");

    $display("[TB] long hold");
    base = cyc;
    expPress.push_back(base + 7);
`ifdef KEY_REPEAT_EN
    for (int i = 0; i < 6; i++) expPress.push_back(base + 17 + 3 * i);
`endif
    applyStimulus(1'b0, 30);
    checkLevels("longHold", 1, 2);
    releaseKey("longRel");
    checkDrained("long");

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
